// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage.
//   fetch_state_e : FSM state encoding (2 bits)
//   PC_INC        : byte distance between consecutive instructions
//   PC_ALIGN_MASK : clears the two low address bits; cast down to PC_WIDTH where used
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        StStart   = 2'd0,
        StFetch   = 2'd1,
        StHold    = 2'd2,
        StDiscard = 2'd3
    } fetch_state_e;

    localparam int unsigned PC_INC = 4;

    // Wide enough for any PC_WIDTH up to 64.
    localparam logic [63:0] PC_ALIGN_MASK = 64'hFFFF_FFFF_FFFF_FFFC;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry skid buffer holding an instruction fetched while decode was stalled.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   load               : capture in_instr/in_pc and mark valid
//   unload             : entry consumed, mark invalid
//   clear              : invalidate (wins over load and unload)
//   in_instr, in_pc    : data to capture
//   instr, pc, valid   : stored entry
module fetch_skid_buffer #(
    parameter int unsigned PC_WIDTH = 32,
    parameter int unsigned IWIDTH   = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                unload,
    input  logic                clear,
    input  logic [IWIDTH-1:0]   in_instr,
    input  logic [PC_WIDTH-1:0] in_pc,
    output logic [IWIDTH-1:0]   instr,
    output logic [PC_WIDTH-1:0] pc,
    output logic                valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr <= '0;
            pc    <= '0;
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            instr <= in_instr;
            pc    <= in_pc;
            valid <= 1'b1;
        end else if (unload) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// First pipeline stage: owns the PC, fetches over a single-outstanding strobe/ack
// handshake, presents instr/pc/ce to decode, honours stall and redirects.
// Ports:
//   fs_clk, fs_rst              : clock, asynchronous active-low reset
//   fs_o_iaddr, fs_o_stb        : memory request (held until fs_i_ack)
//   fs_i_ack, fs_i_instr        : memory response, data valid with ack
//   fs_o_instr, fs_o_pc, fs_o_ce: registered output to decode
//   fs_i_stall                  : decode stalled, outputs hold
//   fs_i_change_pc, fs_i_target_pc : redirect request and (word-aligned) target
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned          PC_WIDTH = 32,
    parameter int unsigned          IWIDTH   = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
    input  logic                fs_clk,
    input  logic                fs_rst,
    output logic [PC_WIDTH-1:0] fs_o_iaddr,
    output logic                fs_o_stb,
    input  logic                fs_i_ack,
    input  logic [IWIDTH-1:0]   fs_i_instr,
    output logic [IWIDTH-1:0]   fs_o_instr,
    output logic [PC_WIDTH-1:0] fs_o_pc,
    output logic                fs_o_ce,
    input  logic                fs_i_stall,
    input  logic                fs_i_change_pc,
    input  logic [PC_WIDTH-1:0] fs_i_target_pc
);

    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = PC_WIDTH'(PC_ALIGN_MASK);
    localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(PC_INC);

    fetch_state_e          state;
    logic [PC_WIDTH-1:0]   pc;
    logic [PC_WIDTH-1:0]   pc_seq;
    logic [PC_WIDTH-1:0]   target;
    logic                  skid_load;
    logic                  skid_unload;
    logic                  skid_clear;
    logic                  skid_valid;
    logic [IWIDTH-1:0]     skid_instr;
    logic [PC_WIDTH-1:0]   skid_pc;

    assign pc_seq = pc + PC_STEP;
    assign target = fs_i_target_pc & ALIGN_MASK;

    always_comb begin
        skid_load   = (state == StFetch) && fs_i_ack && fs_i_stall && !fs_i_change_pc;
        skid_unload = (state == StHold) && !fs_i_stall && !fs_i_change_pc;
        skid_clear  = fs_i_change_pc;
    end

    fetch_skid_buffer #(
        .PC_WIDTH (PC_WIDTH),
        .IWIDTH   (IWIDTH)
    ) u_skid (
        .clk      (fs_clk),
        .rst_n    (fs_rst),
        .load     (skid_load),
        .unload   (skid_unload),
        .clear    (skid_clear),
        .in_instr (fs_i_instr),
        .in_pc    (pc),
        .instr    (skid_instr),
        .pc       (skid_pc),
        .valid    (skid_valid)
    );

    always_ff @(posedge fs_clk or negedge fs_rst) begin
        if (!fs_rst) begin
            state      <= StStart;
            pc         <= RESET_PC;
            fs_o_stb   <= 1'b0;
            fs_o_iaddr <= RESET_PC;
            fs_o_instr <= '0;
            fs_o_pc    <= '0;
            fs_o_ce    <= 1'b0;
        end else if (fs_i_change_pc) begin
            pc      <= target;
            fs_o_ce <= 1'b0;
            if ((state == StFetch || state == StDiscard) && !fs_i_ack) begin
                // A request is still in flight: keep stb/iaddr stable and drop its data.
                state <= StDiscard;
            end else begin
                state      <= StFetch;
                fs_o_stb   <= 1'b1;
                fs_o_iaddr <= target;
            end
        end else begin
            unique case (state)
                StStart: begin
                    state      <= StFetch;
                    fs_o_stb   <= 1'b1;
                    fs_o_iaddr <= pc;
                end
                StFetch: begin
                    if (fs_i_ack) begin
                        pc <= pc_seq;
                        if (fs_i_stall) begin
                            // Data parked in the skid buffer; no new request until drained.
                            state    <= StHold;
                            fs_o_stb <= 1'b0;
                        end else begin
                            fs_o_instr <= fs_i_instr;
                            fs_o_pc    <= pc;
                            fs_o_ce    <= 1'b1;
                            fs_o_iaddr <= pc_seq;
                        end
                    end else if (!fs_i_stall) begin
                        fs_o_ce <= 1'b0;
                    end
                end
                StHold: begin
                    if (!fs_i_stall) begin
                        state      <= StFetch;
                        fs_o_stb   <= 1'b1;
                        fs_o_iaddr <= pc;
                        fs_o_ce    <= skid_valid;
                        if (skid_valid) begin
                            fs_o_instr <= skid_instr;
                            fs_o_pc    <= skid_pc;
                        end
                    end
                end
                StDiscard: begin
                    if (fs_i_ack) begin
                        state      <= StFetch;
                        fs_o_iaddr <= pc;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- First pipeline stage, directly upstream of the decoder stage.
- Keeps the program counter and fetches instructions from instruction memory over a single-outstanding strobe/ack handshake.
- Presents instr/pc/ce to decode and honours decode's stall.
- Redirects on a taken branch or jump, discarding any in-flight fetch.

Parameters:
- PC_WIDTH, 32, program counter and instruction-address width.
- IWIDTH, 32, instruction width.
- RESET_PC, 0, first fetch address after reset.

Ports:
- fs_clk  input  1  clock, rising edge.
- fs_rst  input  1  reset, asynchronous, active-low.
- fs_o_iaddr  output  PC_WIDTH  instruction memory address.
- fs_o_stb  output  1  memory request strobe.
- fs_i_ack  input  1  memory ack; fs_i_instr is valid in the same cycle.
- fs_i_instr  input  IWIDTH  instruction data from memory.
- fs_o_instr  output  IWIDTH  instruction to decode.
- fs_o_pc  output  PC_WIDTH  pc of fs_o_instr.
- fs_o_ce  output  1  fs_o_instr/fs_o_pc valid (feeds decode ce).
- fs_i_stall  input  1  decode stalled; fetch outputs must hold.
- fs_i_change_pc  input  1  redirect request.
- fs_i_target_pc  input  PC_WIDTH  redirect address; bits [1:0] are ignored and treated as 0.

Behaviour:
- Reset (fs_rst=0, async) sets:
  - pc = RESET_PC; state = START.
  - fs_o_stb = 0, fs_o_iaddr = RESET_PC, fs_o_instr = 0, fs_o_pc = 0, fs_o_ce = 0.
  - Skid buffer is cleared.
- Memory protocol:
  - At most one request is outstanding.
  - fs_o_stb and fs_o_iaddr stay constant from assertion until the cycle fs_i_ack=1.
  - Ack latency is at least 1 cycle and otherwise unbounded.
  - The stage ignores fs_i_ack while no request is outstanding.
- States:
  - START: one idle cycle after reset release, stb = 0; then go to FETCH.
  - FETCH: stb = 1, iaddr = pc.
    - ack & !stall: fs_o_instr <= fs_i_instr, fs_o_pc <= pc, fs_o_ce <= 1, pc <= pc+4. Stay in FETCH; the next request issues the following cycle (stb drops for 0 cycles and iaddr advances).
    - ack & stall: capture instr/pc into the skid buffer, pc <= pc+4, go to HOLD. Fetch outputs are unchanged.
    - no ack & !stall: fs_o_ce <= 0.
    - no ack & stall: outputs hold.
  - HOLD: stb = 0.
    - When stall drops: present the skid contents with ce = 1, then go to FETCH.
  - DISCARD: stb stays 1 with the old iaddr until ack. The acked data is dropped and fs_o_ce stays 0. Then go to FETCH at the redirected pc.
- Redirect (fs_i_change_pc=1) has the highest priority over ack and stall:
  - pc <= {fs_i_target_pc[PC_WIDTH-1:2], 2'b00}; fs_o_ce <= 0; skid buffer invalidated.
  - From FETCH with no ack in the same cycle: go to DISCARD.
  - From FETCH with ack in the same cycle: the ack data is dropped; go to FETCH at the target.
  - From HOLD, START, or DISCARD: go to FETCH at the target; a DISCARD in progress stays pending until its ack.
  - A redirect during a stall still takes effect immediately.
- fs_o_pc/fs_o_instr change only when fs_o_ce is loaded with 1 or on reset.
- When fs_o_ce goes to 0, instr/pc hold their last value.
- pc arithmetic is modulo 2^PC_WIDTH: 0xFFFF_FFFC + 4 wraps to 0.
- Reset asserted mid-request: the stage drops stb immediately (async) and forgets the request. The memory must be reset alongside it.
- Latency: the fetch output is registered on the cycle after ack, so an ack in cycle n gives fs_o_ce=1 in cycle n+1.

Decomposition:
- Shared definitions header holds:
  - the FSM state encoding (START, FETCH, HOLD, DISCARD, 2 bits);
  - the PC increment constant (4);
  - the alignment mask.
- The one-entry skid buffer (instr, pc, valid; load/unload/clear) is a natural sub-module: fetch_skid_buffer.
- The PC/FSM logic stays in fetch_stage.

Test Plan:
- Reset release, memory acks 1 cycle after every stb → fs_o_iaddr 0x0,0x4,0x8; fs_o_ce rises 2 cycles after the first stb; fs_o_pc follows 0x0,0x4,0x8 with matching instructions.
- Ack latency 3 cycles → stb/iaddr held constant for 3 cycles; fs_o_ce=1 for exactly one cycle per ack and 0 in between.
- fs_i_stall=1 for 4 cycles while an ack for pc 0x8 arrives → outputs frozen at pc 0x4; when stall drops, pc 0x8 appears with ce=1; no instruction is lost or duplicated.
- fs_i_change_pc=1, target 0x100, while a request to 0xC is outstanding (ack 2 cycles later) → ack data for 0xC never reaches fs_o_*; the next iaddr is 0x100; the first valid output is pc 0x100.
- change_pc in the same cycle as ack and stall, target 0x203 → fs_o_ce=0 next cycle; iaddr becomes 0x200; the skid buffer stays empty.
- RESET_PC=0xFFFF_FFF8 → iaddr sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; async reset pulse mid-request → stb=0 and fs_o_ce=0 immediately, without waiting for a clock edge.
